// File: rtl/fifo_pkg.sv
// Shared configuration for the demo FIFO write and read partitions.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);

    // Committed-word count; one bit wider than an address so it can hold DEPTH.
    typedef logic [ADDR_W:0] level_t;

endpackage

// File: rtl/fifo_writer_wrap_ptr.sv
// Address counter that runs modulo DEPTH. The next value is also exported so
// a caller can look one increment ahead without duplicating the wrap rule.
import fifo_pkg::*;

module wrap_ptr #(
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] ptr_next
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Wrap back to zero after the last entry; no bubble at the wrap point.
    always_comb begin
        ptr_next = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
            ptr_next = '0;
        end
    end

    // Advance the pointer when the caller commits an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fifo_writer.sv
// Write-side stage of the demo FIFO. Each accepted word is staged for one
// cycle and written to the shared memory on the following edge; occupancy
// counts only committed words, while full also counts the staged word so the
// slot it will occupy is reserved.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready are
// both high in the preceding cycle; in_ready depends only on registered state,
// and in_data is ignored in any cycle without a transfer.
import fifo_pkg::*;

module fifo_writer #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              underflow
);

    logic              pending;
    logic              accept;
    logic              commit;
    logic              rd_ok;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] next_waddr;
    logic [ADDR_W+1:0] occupied;

    wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (commit),
        .ptr      (wr_ptr),
        .ptr_next (wr_ptr_next)
    );

    // Occupancy flags and handshake qualifiers, all from registered state.
    always_comb begin
        occupied = {1'b0, level} + {{(ADDR_W+1){1'b0}}, pending};
        full     = (occupied == (ADDR_W+2)'(DEPTH));
        empty    = (level == '0);
        in_ready = !full;
        accept   = in_valid && in_ready;
        commit   = pending;
        rd_ok    = rd_en && !empty;
        // A commit in this cycle advances wr_ptr at the same edge, so a
        // back-to-back word must take the address after it.
        next_waddr = commit ? wr_ptr_next : wr_ptr;
    end

    assign mem_we = pending;

    // Stage an accepted word: the write strobe is high for exactly one cycle
    // per word, and data/address hold their last values otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            pending <= accept;
            if (accept) begin
                mem_waddr <= next_waddr;
                mem_wdata <= in_data;
            end
        end
    end

    // Committed-word count: commits add, valid reads remove, both cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({commit, rd_ok})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky underflow; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (rd_en && empty) begin
            underflow <= 1'b1;
        end else if (clr_err) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_writer.sv
// Bench for fifo_writer: directed vectors with literal expectations, plus a
// queue-based model of accepted words and committed count compared every cycle.
import fifo_pkg::*;

module tb_fifo_writer;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;
    logic              underflow;

    always #5 clk = ~clk;

    fifo_writer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .underflow (underflow)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words accepted but not yet seen on the memory port: {addr, data}.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int m_committed;   // words readable by the reader
    int m_in_flight;   // words accepted but not yet readable (0 or 1)
    int m_accepts;     // accepts since reset; address = accepts mod DEPTH
    bit m_uf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_committed = 0;
            m_in_flight = 0;
            m_accepts   = 0;
            m_uf        = 0;
        end else begin
            bit acc;
            int nxt;
            acc = in_valid && (m_committed + m_in_flight < DEPTH);
            nxt = m_committed + m_in_flight;
            if (rd_en && m_committed > 0) nxt = nxt - 1;
            if (rd_en && m_committed == 0) m_uf = 1;
            else if (clr_err) m_uf = 0;
            if (acc) begin
                exp_q.push_back({ADDR_W'(m_accepts % DEPTH), in_data});
                m_accepts++;
            end
            m_committed = nxt;
            m_in_flight = acc ? 1 : 0;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (!rst) begin
            logic [ADDR_W+DATA_W-1:0] e;
            chk("level",     32'(level),     32'(m_committed));
            chk("full",      32'(full),      32'(m_committed + m_in_flight == DEPTH));
            chk("in_ready",  32'(in_ready),  32'(m_committed + m_in_flight != DEPTH));
            chk("empty",     32'(empty),     32'(m_committed == 0));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk("mem_we",    32'(mem_we),    32'(m_in_flight));
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("write_expected", 32'(0), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_waddr", 32'(mem_waddr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    chk("mem_wdata", 32'(mem_wdata), 32'(e[DATA_W-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Apply inputs for one cycle; returns 1 time unit after the edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit c);
        in_valid = v;
        in_data  = d;
        rd_en    = r;
        clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; rd_en = 0; clr_err = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        do_reset();
        chk("rst_level",    32'(level),     0);
        chk("rst_empty",    32'(empty),     1);
        chk("rst_full",     32'(full),      0);
        chk("rst_in_ready", 32'(in_ready),  1);
        chk("rst_mem_we",   32'(mem_we),    0);
        chk("rst_waddr",    32'(mem_waddr), 0);
        chk("rst_wdata",    32'(mem_wdata), 0);
        chk("rst_uf",       32'(underflow), 0);

        // Single word: written one cycle after acceptance, readable after two.
        step(1, 8'hA5, 0, 0);
        chk("t1_we",    32'(mem_we),    1);
        chk("t1_addr",  32'(mem_waddr), 0);
        chk("t1_data",  32'(mem_wdata), 32'h A5);
        chk("t1_empty", 32'(empty),     1);
        step(0, 8'h00, 0, 0);
        chk("t1_level", 32'(level),  1);
        chk("t1_ne",    32'(empty),  0);
        chk("t1_we0",   32'(mem_we), 0);

        // Fill 256 words with no reads.
        do_reset();
        for (int i = 0; i < 256; i++) step(1, DATA_W'(i), 0, 0);
        chk("fill_full",  32'(full),      1);
        chk("fill_rdy",   32'(in_ready),  0);
        chk("fill_level", 32'(level),     255);
        chk("fill_addr",  32'(mem_waddr), 32'h FF);
        chk("fill_data",  32'(mem_wdata), 32'h FF);
        step(1, 8'h77, 0, 0);
        chk("full_level", 32'(level),  256);
        chk("full_we0",   32'(mem_we), 0);
        step(1, 8'h78, 0, 0);
        chk("full_we1",   32'(mem_we), 0);
        chk("full_hold",  32'(full),   1);

        // One read from full, then the next word wraps to address 0.
        step(0, 8'h00, 1, 0);
        chk("rd_level", 32'(level),    255);
        chk("rd_rdy",   32'(in_ready), 1);
        step(1, 8'hC3, 0, 0);
        chk("wrap_we",   32'(mem_we),    1);
        chk("wrap_addr", 32'(mem_waddr), 0);
        chk("wrap_data", 32'(mem_wdata), 32'h C3);
        step(0, 8'h00, 0, 0);
        chk("wrap_full", 32'(full), 1);

        // Steady write+read: four committed plus one staged keeps level at 4.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, DATA_W'(8'h10 + i), 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, DATA_W'(8'h40 + i), 1, 0);
            chk("ss_level", 32'(level),     4);
            chk("ss_addr",  32'(mem_waddr), 32'(5 + i));
            chk("ss_full",  32'(full),      0);
            chk("ss_empty", 32'(empty),     0);
        end

        // Underflow, clear, and clear coinciding with a new event.
        do_reset();
        step(0, 8'h00, 1, 0);
        chk("uf_level", 32'(level),     0);
        chk("uf_set",   32'(underflow), 1);
        step(0, 8'h00, 0, 1);
        chk("uf_clr",   32'(underflow), 0);
        step(0, 8'h00, 1, 1);
        chk("uf_win",   32'(underflow), 1);
        step(0, 8'h00, 0, 1);

        // Reset while a word is staged: strobe drops at once, nothing commits.
        step(1, 8'h5A, 0, 0);
        chk("mid_we", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        chk("mid_we0",  32'(mem_we),   0);
        chk("mid_lvl",  32'(level),    0);
        chk("mid_rdy",  32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 8'h11, 0, 0);
        chk("mid_addr", 32'(mem_waddr), 0);
        chk("mid_data", 32'(mem_wdata), 32'h 11);

        // Mixed traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), DATA_W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("q_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
